mul_share_arbiter: RTL
======================

Name: mul_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational half-width floating-point multiplier (16-bit operands: 6-bit exponent, 10-bit fraction) among NUM_REQ requesters. It accepts one operand pair at a time with a valid/ready handshake and registers the operands onto the multiplier inputs. It waits a fixed settle time, captures the multiplier result and returns it tagged with the requester ID. It sits between the requesting datapath blocks and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ))
SETTLE_CYCLES, 2, cycles the registered operands are held before the result is sampled (1..15)
ZERO_BYPASS, 1, when 1, an operand pair with either operand == 16'h0000 skips the settle wait and returns 16'h0000

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active high
req_valid  input  NUM_REQ  per-requester operand-valid
req_ready  output  NUM_REQ  per-requester accept strobe (one-hot or zero)
req_a  input  16*NUM_REQ  packed operand A; requester k uses bits [16k+15:16k]
req_b  input  16*NUM_REQ  packed operand B, same packing
mul_a  output  16  registered operand A to shared multiplier
mul_b  output  16  registered operand B to shared multiplier
mul_sum  input  16  multiplier result {exponent[5:0], fraction[9:0]}
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  requester index owning the result
rsp_sum  output  16  captured result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; rr_ptr=0; mul_a, mul_b, rsp_sum = 16'h0000; rsp_id=0; rsp_valid=0; req_ready=0; busy=0. Asserting reset in any state aborts the operation: no response is produced, and any accepted request is lost.
- States: IDLE, SETTLE, RESP.
- IDLE: the grant is the first k with req_valid[k]=1, searched from rr_ptr upward with wrap modulo NUM_REQ. req_ready[k] is asserted combinationally in the same cycle and is never asserted outside IDLE. On that clock edge:
  - mul_a, mul_b and the ID register load req_a[k], req_b[k] and k.
  - With ZERO_BYPASS=1 and either operand == 0: rsp_sum=0, rsp_valid=1, next state RESP.
  - Otherwise: cnt=SETTLE_CYCLES-1, next state SETTLE.
  - If no req_valid is set, the block stays in IDLE.
- SETTLE: mul_a and mul_b are held stable. cnt decrements each cycle. When cnt==0, rsp_sum<=mul_sum, rsp_valid<=1, next state RESP. The result is therefore sampled SETTLE_CYCLES cycles after acceptance.
- RESP: rsp_valid, rsp_id and rsp_sum are held until rsp_ready=1. On the handshake edge: rsp_valid<=0, rr_ptr<=(rsp_id+1) mod NUM_REQ, next state IDLE.
  - No new request is accepted in the handshake cycle.
  - Minimum request-to-request spacing is SETTLE_CYCLES+2 cycles, or 2 cycles with a zero bypass.
- mul_a and mul_b keep their last values after completion; they are not cleared.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 other operations.
- A requester deasserting req_valid before it is granted is legal, and no state is kept for it. After acceptance, changes on req_* are ignored.
- rsp_ready held high continuously is legal. rsp_ready while rsp_valid=0 is ignored.

Test Plan:
- Reset then single request: req_valid=4'b0001, req_a=16'h7C00, req_b=16'h7E00, mul_sum stub=16'hA5A5 -> req_ready=4'b0001 for 1 cycle; mul_a=16'h7C00, mul_b=16'h7E00 one edge later; rsp_valid rises 2 cycles after acceptance with rsp_sum=16'hA5A5, rsp_id=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 4 cycles apart; rsp_id follows the same sequence.
- Back-pressure: rsp_ready=0 for 10 cycles while the stub changes mul_sum -> rsp_sum stays at the sampled value, req_ready stays 0, busy=1; with rsp_ready=1 the block returns to IDLE next cycle.
- Zero bypass: req_b=16'h0000 from requester 2 -> rsp_valid one cycle after acceptance, rsp_sum=16'h0000, rsp_id=2, no SETTLE state.
- Async reset asserted mid-SETTLE -> all outputs 0 immediately without a clock edge; no rsp_valid is produced after release; rr_ptr=0, so requester 0 wins the next contention.
- Wrap-around: rr_ptr=3 with req_valid=4'b1001 -> requester 3 is granted first, then 0.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that shares one combinational half-width FP multiplier
// among NUM_REQ requesters: accept, hold operands for a settle time, return tagged result.
module mul_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int ZERO_BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [15:0]           mul_a,
    output logic [15:0]           mul_b,
    input  logic [15:0]           mul_sum,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_sum,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     mul_a_q, mul_a_d;
    logic [15:0]     mul_b_q, mul_b_d;
    logic [15:0]     rsp_sum_q, rsp_sum_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [15:0]     a_arr [NUM_REQ];
    logic [15:0]     b_arr [NUM_REQ];
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [15:0]     grant_a, grant_b;
    logic            grant_zero;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[16*g +: 16];
        assign b_arr[g] = req_b[16*g +: 16];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_a     = '0;
        grant_b     = '0;
        cand        = 0;
        cand_id     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
                grant_a     = a_arr[cand_id];
                grant_b     = b_arr[cand_id];
            end
        end
        grant_zero = (ZERO_BYPASS != 0) && ((grant_a == 16'h0000) || (grant_b == 16'h0000));
    end

    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && grant_found && !rst) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    mul_a_d = grant_a;
                    mul_b_d = grant_b;
                    id_d    = grant_idx;
                    if (grant_zero) begin
                        rsp_sum_d   = 16'h0000;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_sum_d   = mul_sum;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Pointer moves past the owner only once the result has been taken.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule
